lfsr_stream: RTL and testbench

- Runtime-configurable LFSR pseudo-random word generator with a valid/ready output stream.
- Successor to the fixed-polynomial 3..32-bit generator. Taps, seed and mode (Fibonacci-XNOR or Galois-XOR) are loaded through a config handshake, not fixed per width.
- Adds start/stop control, output backpressure, lock-up seed rejection and sequence-period measurement.
- Feeds BIST pattern sources and scramblers in the test datapath.

---
 rtl/lfsr_pkg.sv | 26 ++
 rtl/lfsr_step.sv | 26 ++
 rtl/lfsr_stream.sv | 145 ++++++++++++++
 tb/tb_lfsr_stream.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared types and helpers for the runtime-configurable LFSR stream generator.
// Used by lfsr_step and lfsr_stream.
package lfsr_pkg;

    localparam int WIDTH_MIN = 3;
    localparam int WIDTH_MAX = 32;

    typedef enum logic {
        LFSR_FIB_XNOR = 1'b0,
        LFSR_GAL_XOR  = 1'b1
    } lfsr_mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } lfsr_state_e;

    // State that the selected feedback can never leave; returned zero-extended to WIDTH_MAX.
    function automatic logic [WIDTH_MAX-1:0] lockup_value(input lfsr_mode_e mode, input int width);
        if (mode == LFSR_FIB_XNOR) begin
            return {WIDTH_MAX{1'b1}} >> (WIDTH_MAX - width);
        end
        return '0;
    endfunction

endpackage

// File: rtl/lfsr_step.sv
// Combinational single-step LFSR next-state (Fibonacci-XNOR or Galois-XOR).
// Shared with the scrambler datapath.
module lfsr_step
    import lfsr_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_state,
    input  logic [WIDTH-1:0] i_taps,
    input  lfsr_mode_e       i_mode,
    output logic [WIDTH-1:0] o_next
);

    logic w_fib_fb;

    assign w_fib_fb = ~(^(i_state & i_taps));

    // NOTE: the first assignment is an unconditional default, so no path leaves o_next unassigned and no latch is inferred.
    always_comb begin
        o_next = {i_state[WIDTH-2:0], w_fib_fb};
        if (i_mode == LFSR_GAL_XOR) begin
            o_next = {i_state[WIDTH-2:0], 1'b0} ^ (i_state[WIDTH-1] ? i_taps : '0);
        end
    end

endmodule

// File: rtl/lfsr_stream.sv
// Runtime-configurable LFSR word generator with valid/ready output and period measurement.
// Optional macro LFSR_PERIOD_CNT_EN enables the step counter and period_cnt_o.
module lfsr_stream
    import lfsr_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cfg_valid_i,
    output logic             cfg_ready_o,
    input  logic             cfg_mode_i,
    input  logic [WIDTH-1:0] cfg_taps_i,
    input  logic [WIDTH-1:0] cfg_seed_i,
    output logic             cfg_err_o,
    input  logic             start_i,
    input  logic             stop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             data_valid_o,
    input  logic             data_ready_i,
    output logic             period_done_o,
    output logic [WIDTH-1:0] period_cnt_o,
    output logic             busy_o
);

    generate
        if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
            $error("lfsr_stream: WIDTH out of range 3..32");
        end
    endgenerate

    lfsr_state_e      r_state;
    lfsr_state_e      w_state_nxt;
    lfsr_mode_e       r_mode;
    lfsr_mode_e       w_cfg_mode;
    logic [WIDTH-1:0] r_lfsr;
    logic [WIDTH-1:0] r_taps;
    logic [WIDTH-1:0] r_seed;
    logic             r_configured;
    logic             r_cfg_err;
    logic             r_period_done;
    logic [WIDTH-1:0] w_next;
    logic             w_cfg_fire;
    logic             w_cfg_bad;
    logic             w_accept;
    logic             w_wrap;
    logic [WIDTH_MAX-1:0] w_seed_ext;

    assign w_cfg_mode = lfsr_mode_e'(cfg_mode_i);
    assign w_seed_ext = WIDTH_MAX'(cfg_seed_i);
    assign w_cfg_fire = cfg_valid_i && (r_state == ST_IDLE);
    assign w_cfg_bad  = ((w_cfg_mode == LFSR_FIB_XNOR) && !cfg_taps_i[WIDTH-1])
                     || ((w_cfg_mode == LFSR_GAL_XOR)  && !cfg_taps_i[0])
                     || (w_seed_ext == lockup_value(w_cfg_mode, WIDTH));
    assign w_accept   = (r_state == ST_RUN) && data_ready_i;
    assign w_wrap     = (w_next == r_seed);

    lfsr_step #(.WIDTH(WIDTH)) u_step (
        .i_state (r_lfsr),
        .i_taps  (r_taps),
        .i_mode  (r_mode),
        .o_next  (w_next)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start_i && r_configured) w_state_nxt = ST_RUN;
            ST_RUN:  if (stop_i)                  w_state_nxt = ST_IDLE;
            default:                              w_state_nxt = ST_IDLE;
        endcase
    end

    // Config and stepping are mutually exclusive: config fires only in IDLE, accepts only in RUN.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_mode        <= LFSR_FIB_XNOR;
            r_lfsr        <= '0;
            r_taps        <= '0;
            r_seed        <= '0;
            r_configured  <= 1'b0;
            r_cfg_err     <= 1'b0;
            r_period_done <= 1'b0;
        end else begin
            r_cfg_err     <= 1'b0;
            r_period_done <= 1'b0;
            if (w_cfg_fire) begin
                if (w_cfg_bad) begin
                    r_cfg_err <= 1'b1;
                end else begin
                    r_mode       <= w_cfg_mode;
                    r_taps       <= cfg_taps_i;
                    r_seed       <= cfg_seed_i;
                    r_lfsr       <= cfg_seed_i;
                    r_configured <= 1'b1;
                end
            end else if (w_accept) begin
                r_lfsr        <= w_next;
                r_period_done <= w_wrap;
            end
        end
    end

`ifdef LFSR_PERIOD_CNT_EN
    logic [WIDTH-1:0] r_step_cnt;
    logic [WIDTH-1:0] r_period_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_step_cnt   <= '0;
            r_period_cnt <= '0;
        end else if (w_cfg_fire && !w_cfg_bad) begin
            r_step_cnt <= '0;
        end else if (w_accept) begin
            if (w_wrap) begin
                r_period_cnt <= r_step_cnt + 1'b1;
                r_step_cnt   <= '0;
            end else begin
                r_step_cnt <= r_step_cnt + 1'b1;
            end
        end
    end

    assign period_cnt_o = r_period_cnt;
`else
    assign period_cnt_o = '0;
`endif

    assign cfg_ready_o   = (r_state == ST_IDLE);
    assign cfg_err_o     = r_cfg_err;
    assign data_o        = r_lfsr;
    assign data_valid_o  = (r_state == ST_RUN);
    assign busy_o        = (r_state == ST_RUN);
    assign period_done_o = r_period_done;

endmodule

// File: tb/tb_lfsr_stream.sv
// Scoreboard bench for lfsr_stream at WIDTH=4: stimulus pushes the model sequence,
// a negedge monitor pops and compares every presented word and period pulse.
module tb_lfsr_stream;

    localparam int W = 4;
`ifdef LFSR_PERIOD_CNT_EN
    localparam bit PER_EN = 1'b1;
`else
    localparam bit PER_EN = 1'b0;
`endif

    typedef struct {
        logic [W-1:0] data;
        logic         pd;
        logic [W-1:0] per;
    } item_t;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic         cfg_valid_i = 1'b0;
    logic         cfg_ready_o;
    logic         cfg_mode_i = 1'b0;
    logic [W-1:0] cfg_taps_i = '0;
    logic [W-1:0] cfg_seed_i = '0;
    logic         cfg_err_o;
    logic         start_i = 1'b0;
    logic         stop_i = 1'b0;
    logic [W-1:0] data_o;
    logic         data_valid_o;
    logic         data_ready_i = 1'b0;
    logic         period_done_o;
    logic [W-1:0] period_cnt_o;
    logic         busy_o;

    int total = 0;
    int bad   = 0;

    item_t        sb_q[$];
    logic         mon_pending = 1'b0;
    logic         mon_pd = 1'b0;
    logic [W-1:0] mon_per = '0;

    lfsr_stream #(.WIDTH(W)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .cfg_valid_i   (cfg_valid_i),
        .cfg_ready_o   (cfg_ready_o),
        .cfg_mode_i    (cfg_mode_i),
        .cfg_taps_i    (cfg_taps_i),
        .cfg_seed_i    (cfg_seed_i),
        .cfg_err_o     (cfg_err_o),
        .start_i       (start_i),
        .stop_i        (stop_i),
        .data_o        (data_o),
        .data_valid_o  (data_valid_o),
        .data_ready_i  (data_ready_i),
        .period_done_o (period_done_o),
        .period_cnt_o  (period_cnt_o),
        .busy_o        (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Fibonacci: shift in 1 when the tapped bits have even parity.
    // Galois: multiply by x modulo the polynomial x^W + taps.
    function automatic logic [W-1:0] model_next(input logic mode, input logic [W-1:0] taps,
                                                input logic [W-1:0] s);
        int v;
        if (!mode) begin
            return {s[W-2:0], ($countones(s & taps) % 2 == 0)};
        end
        v = int'(s) * 2;
        if (v >= (1 << W)) v = (v - (1 << W)) ^ int'(taps);
        return W'(v);
    endfunction

    task automatic load_model(input logic mode, input logic [W-1:0] taps, input logic [W-1:0] seed);
        item_t        it;
        logic [W-1:0] w;
        int           last;
        sb_q.delete();
        mon_pending = 1'b0;
        w = seed;
        last = 0;
        it.data = seed; it.pd = 1'b0; it.per = '0;
        sb_q.push_back(it);
        for (int k = 1; k < 200; k++) begin
            w = model_next(mode, taps, w);
            it.data = w;
            it.pd   = (w == seed);
            it.per  = (it.pd && PER_EN) ? W'(k - last) : '0;
            if (it.pd) last = k;
            sb_q.push_back(it);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic do_cfg(input logic mode, input logic [W-1:0] taps, input logic [W-1:0] seed,
                          input logic exp_err, input string name);
        cfg_mode_i  = mode;
        cfg_taps_i  = taps;
        cfg_seed_i  = seed;
        cfg_valid_i = 1'b1;
        tick(1);
        cfg_valid_i = 1'b0;
        check({name, "_err"}, 32'(cfg_err_o), 32'(exp_err));
        if (!exp_err) load_model(mode, taps, seed);
        tick(1);
        check({name, "_err_clear"}, 32'(cfg_err_o), 32'(0));
    endtask

    task automatic try_start(input string name);
        start_i = 1'b1;
        tick(1);
        start_i = 1'b0;
        check(name, 32'(busy_o), 32'(0));
    endtask

    // Monitor: compares every presented word; after each accept, checks the period pulse one cycle later.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (mon_pending) begin
                check("period_done", 32'(period_done_o), 32'(mon_pd));
                if (mon_pd) check("period_cnt", 32'(period_cnt_o), 32'(mon_per));
                mon_pending = 1'b0;
            end else begin
                check("period_done_spurious", 32'(period_done_o), 32'(0));
            end
            if (data_valid_o) begin
                check("sb_nonempty", 32'(sb_q.size() > 0), 32'(1));
                if (sb_q.size() > 0) begin
                    check("data", 32'(data_o), 32'(sb_q[0].data));
                    if (data_ready_i) begin
                        void'(sb_q.pop_front());
                        mon_pending = 1'b1;
                        mon_pd  = (sb_q.size() > 0) ? sb_q[0].pd  : 1'b0;
                        mon_per = (sb_q.size() > 0) ? sb_q[0].per : '0;
                    end
                end
            end
        end
    end

    task automatic check_reset_outputs(input string name);
        check({name, "_data"},   32'(data_o),        32'(0));
        check({name, "_valid"},  32'(data_valid_o),  32'(0));
        check({name, "_busy"},   32'(busy_o),        32'(0));
        check({name, "_ready"},  32'(cfg_ready_o),   32'(1));
        check({name, "_err"},    32'(cfg_err_o),     32'(0));
        check({name, "_pdone"},  32'(period_done_o), 32'(0));
        check({name, "_pcnt"},   32'(period_cnt_o),  32'(0));
    endtask

    initial begin
        logic found;

        tick(2);
        rst_i = 1'b0;
        check_reset_outputs("reset");
        try_start("start_unconfigured");

        do_cfg(1'b0, 4'b1100, 4'b1111, 1'b1, "rej_fib_lockup");
        try_start("start_after_rej_a");
        do_cfg(1'b1, 4'b1001, 4'b0000, 1'b1, "rej_gal_lockup");
        try_start("start_after_rej_b");
        do_cfg(1'b0, 4'b0100, 4'b0001, 1'b1, "rej_fib_taps");
        try_start("start_after_rej_c");
        do_cfg(1'b1, 4'b1000, 4'b0001, 1'b1, "rej_gal_taps");

        // Fibonacci run, stop together with the accept of 0111, then resume.
        do_cfg(1'b0, 4'b1100, 4'b0000, 1'b0, "cfg_fib");
        check("fib_seed_loaded", 32'(data_o), 32'(4'b0000));
        data_ready_i = 1'b1;
        start_i = 1'b1;
        tick(1);
        start_i = 1'b0;
        check("fib_busy", 32'(busy_o), 32'(1));
        check("cfg_ready_in_run", 32'(cfg_ready_o), 32'(0));
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            if (data_valid_o && data_o == 4'b0111) found = 1'b1;
            else tick(1);
        end
        check("wait_0111", 32'(found), 32'(1));
        stop_i = 1'b1;
        tick(1);
        stop_i = 1'b0;
        check("stop_busy", 32'(busy_o), 32'(0));
        check("stop_valid", 32'(data_valid_o), 32'(0));
        check("stop_cfg_ready", 32'(cfg_ready_o), 32'(1));
        tick(3);
        start_i = 1'b1;
        tick(1);
        start_i = 1'b0;
        tick(20);

        // Backpressure: word held for 5 cycles, then random ready.
        data_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check("bp_valid", 32'(data_valid_o), 32'(1));
        end
        // A config request while running must be ignored entirely.
        cfg_mode_i = 1'b0; cfg_taps_i = 4'b1100; cfg_seed_i = 4'b1111;
        cfg_valid_i = 1'b1;
        tick(1);
        cfg_valid_i = 1'b0;
        tick(1);
        check("cfg_in_run_no_err", 32'(cfg_err_o), 32'(0));
        for (int i = 0; i < 40; i++) begin
            data_ready_i = 1'($urandom_range(0, 1));
            tick(1);
        end
        data_ready_i = 1'b0;
        stop_i = 1'b1;
        tick(1);
        stop_i = 1'b0;
        check("fib_stopped", 32'(busy_o), 32'(0));

        // Galois config in IDLE reloads the seed; random-ready run.
        do_cfg(1'b1, 4'b1001, 4'b0001, 1'b0, "cfg_gal");
        check("gal_seed_loaded", 32'(data_o), 32'(4'b0001));
        data_ready_i = 1'b1;
        start_i = 1'b1;
        tick(1);
        start_i = 1'b0;
        tick(20);
        for (int i = 0; i < 80; i++) begin
            data_ready_i = 1'($urandom_range(0, 1));
            tick(1);
        end

        // Reset while running: configuration is lost.
        data_ready_i = 1'b1;
        rst_i = 1'b1;
        tick(1);
        rst_i = 1'b0;
        sb_q.delete();
        mon_pending = 1'b0;
        check_reset_outputs("midrun_reset");
        try_start("start_after_reset");
        tick(2);
        check("idle_after_reset", 32'(data_valid_o), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
